// File: rtl/ahb_slave_mux.sv
// AHB-Lite data-phase return mux with built-in default slave (two-cycle ERROR for unmapped transfers).
// Optional macro AHB_MUX_ERR_COUNT_EN adds a saturating 8-bit default-slave error counter on ERR_COUNT.
module ahb_slave_mux #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SLAVE_COUNT = 4
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [SLAVE_COUNT-1:0]            HSEL,
  input  logic [1:0]                        HTRANS,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [SLAVE_COUNT-1:0]            HREADYOUT_S,
  input  logic [SLAVE_COUNT-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]             HRDATA,
  output logic                              HREADY,
  output logic                              HRESP,
  output logic [7:0]                        ERR_COUNT
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [SLAVE_COUNT-1:0]  dsel;
  logic [SLAVE_COUNT-1:0]  sel_low;
  logic                    unmapped_act;
  logic [DATA_WIDTH-1:0]   mux_rdata;
  logic                    mux_ready;
  logic                    mux_resp;
  logic                    unused_htrans;

  // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
  assign unused_htrans = HTRANS[0];
  assign unmapped_act  = (HSEL == '0) && HTRANS[1];

  // Lowest-index priority reduction of a possibly multi-hot select.
  always_comb begin
    logic found;
    sel_low = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(SLAVE_COUNT); i++) begin
      if (HSEL[i] && !found) begin
        sel_low[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= DEF_IDLE;
      dsel  <= '0;
    end else begin
      state <= state_next;
      if (HREADY) begin
        dsel <= sel_low;
      end
    end
  end

  // Return-path mux from the data-phase slave.
  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b1;
    mux_resp  = 1'b0;
    for (int i = 0; i < int'(SLAVE_COUNT); i++) begin
      if (dsel[i]) begin
        mux_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_ready = HREADYOUT_S[i];
        mux_resp  = HRESP_S[i];
      end
    end
  end

  // Default-slave FSM: next state and master-facing outputs.
  always_comb begin
    state_next = state;
    HRDATA     = mux_rdata;
    HREADY     = mux_ready;
    HRESP      = mux_resp;
    case (state)
      DEF_IDLE: begin
        if (mux_ready && unmapped_act) begin
          state_next = DEF_ERR1;
        end
      end
      DEF_ERR1: begin
        HRDATA     = '0;
        HREADY     = 1'b0;
        HRESP      = 1'b1;
        state_next = DEF_ERR2;
      end
      DEF_ERR2: begin
        HRDATA     = '0;
        HREADY     = 1'b1;
        HRESP      = 1'b1;
        state_next = unmapped_act ? DEF_ERR1 : DEF_IDLE;
      end
      default: begin
        state_next = DEF_IDLE;
      end
    endcase
  end

`ifdef AHB_MUX_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count;

  // Counts entries into DEF_ERR1; holds at all-ones.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_count <= '0;
    end else if ((state_next == DEF_ERR1) && (state != DEF_ERR1) &&
                 (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  assign ERR_COUNT = err_count;
`else
  assign ERR_COUNT = CNT_W'(0);
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_ahb_slave_mux;

  localparam int unsigned DW = 32;
  localparam int unsigned SC = 4;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic [SC-1:0]      HSEL;
  logic [1:0]         HTRANS;
  logic [SC*DW-1:0]   HRDATA_S;
  logic [SC-1:0]      HREADYOUT_S;
  logic [SC-1:0]      HRESP_S;
  logic [DW-1:0]      HRDATA;
  logic               HREADY;
  logic               HRESP;
  logic [7:0]         ERR_COUNT;

  ahb_slave_mux #(.DATA_WIDTH(DW), .SLAVE_COUNT(SC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .ERR_COUNT(ERR_COUNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        ready;
    logic        resp;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [7:0] ec(input int n);
`ifdef AHB_MUX_ERR_COUNT_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  // Monitor: compare the expectation scheduled for this cycle.
  always @(negedge HCLK) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (HRDATA !== e.rdata) begin
        errors++;
        $display("FAIL %s HRDATA: got %h want %h", e.name, HRDATA, e.rdata);
      end
      checks++;
      if (HREADY !== e.ready) begin
        errors++;
        $display("FAIL %s HREADY: got %b want %b", e.name, HREADY, e.ready);
      end
      checks++;
      if (HRESP !== e.resp) begin
        errors++;
        $display("FAIL %s HRESP: got %b want %b", e.name, HRESP, e.resp);
      end
      checks++;
      if (ERR_COUNT !== e.cnt) begin
        errors++;
        $display("FAIL %s ERR_COUNT: got %0d want %0d", e.name, ERR_COUNT, e.cnt);
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] hsel, input logic [1:0] htrans,
                       input logic [3:0] rdy, input logic [3:0] rsp);
    @(posedge HCLK);
    #1;
    HRESET      = rst;
    HSEL        = hsel;
    HTRANS      = htrans;
    HREADYOUT_S = rdy;
    HRESP_S     = rsp;
  endtask

  task automatic expect_now(input logic [31:0] d, input logic r, input logic e,
                            input logic [7:0] n, input string nm);
    exp_t x;
    x.cyc = cyc; x.rdata = d; x.ready = r; x.resp = e; x.cnt = n; x.name = nm;
    q.push_back(x);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = '0; HTRANS = 2'b00;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;

    // 1: reset with random slave inputs
    drive(1'b1, 4'b0000, 2'b00, 4'($urandom), 4'($urandom));
    HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, 4'b0000, 2'b00, 4'($urandom), 4'($urandom));
    HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "reset");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    HRDATA_S = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "post_reset");

    // 2: zero-wait read from slave 2
    drive(1'b0, 4'b0100, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "s2_addr");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'hCAFE_0002, 1'b1, 1'b0, 8'd0, "s2_data");

    // 3: slave 1 with three wait states while the master presents slave 3
    drive(1'b0, 4'b0010, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "s1_addr");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1000, 2'b10, 4'b1101, 4'b0000);
      expect_now(32'hCAFE_0001, 1'b0, 1'b0, 8'd0, "s1_wait");
    end
    drive(1'b0, 4'b1000, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'hCAFE_0001, 1'b1, 1'b0, 8'd0, "s1_done");
    drive(1'b0, 4'b0110, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'hCAFE_0003, 1'b1, 1'b0, 8'd0, "s3_data");
    // multi-hot 0110 must resolve to slave 1; slave 2 not ready would expose a wrong pick
    drive(1'b0, 4'b0000, 2'b00, 4'b1011, 4'b0100);
    expect_now(32'hCAFE_0001, 1'b1, 1'b0, 8'd0, "multihot");

    // 5: unmapped BUSY and IDLE stay zero-wait OKAY
    drive(1'b0, 4'b0000, 2'b01, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "unmapped_busy");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "unmapped_idle");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "idle_no_err");

    // 4: unmapped NONSEQ -> two-cycle ERROR
    drive(1'b0, 4'b0000, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "unm_addr");
    drive(1'b0, 4'b0000, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b0, 1'b1, ec(1), "err1");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b1, ec(1), "err2");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, ec(1), "err_done");

    // slave-generated ERROR passes through without touching the counter
    drive(1'b0, 4'b0001, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, ec(1), "s0_addr");
    drive(1'b0, 4'b0000, 2'b00, 4'b1110, 4'b0001);
    expect_now(32'hCAFE_0000, 1'b0, 1'b1, ec(1), "s0_err1");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0001);
    expect_now(32'hCAFE_0000, 1'b1, 1'b1, ec(1), "s0_err2");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, ec(1), "s0_done");

    // 6: back-to-back unmapped errors, then reset during DEF_ERR1
    drive(1'b0, 4'b0000, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, ec(1), "b2b_addr");
    drive(1'b0, 4'b0100, 2'b10, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b0, 1'b1, ec(2), "b2b_err1a");
    drive(1'b0, 4'b0000, 2'b11, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b1, ec(2), "b2b_err2a");
    drive(1'b1, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b0, 1'b1, ec(3), "b2b_err1b");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "rst_mid_err");
    drive(1'b0, 4'b0000, 2'b00, 4'b1111, 4'b0000);
    expect_now(32'h0, 1'b1, 1'b0, 8'd0, "after_rst");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge HCLK);
    #2;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
